// File: rtl/mips_pkg.sv
// Shared opcode constants and enums for the dual-issue front end.
// Imported by the decoder and the scheduler top.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic {CLS_I, CLS_R} cls_e;

    typedef enum logic [1:0] {EMPTY, ISSUE, LU_STALL} state_e;

endpackage

// File: rtl/inst_decode_lite.sv
// Minimal MIPS decode: issue class, branch flag, source mask and destination.
// Register 0 is dropped from both source mask and destination.
module inst_decode_lite
    import mips_pkg::*;
(
    input  logic [31:11] instr,
    output cls_e         cls,
    output logic         is_branch,
    output logic [31:0]  src,
    output logic [4:0]   dst,
    output logic         dst_vld
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op = instr[31:26];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign rd = instr[15:11];

    always_comb begin
        cls       = (op == OP_RTYPE) ? CLS_R : CLS_I;
        is_branch = (op == OP_BEQ) || (op == OP_BNE);
        src       = '0;
        src[rs]   = 1'b1;
        if (op == OP_RTYPE || op == OP_SW || is_branch)
            src[rt] = 1'b1;
        src[0] = 1'b0;
        dst = '0;
        if (op == OP_RTYPE)
            dst = rd;
        else if (op == OP_LW || op == OP_ADDI)
            dst = rt;
        dst_vld = (dst != 5'd0);
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Pair queue between fetch and ID/EX issuing up to one I-class and one
// R-class instruction per cycle in program order.
module dual_issue_scheduler
    import mips_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int DW     = 32,
    parameter int CW     = 16
) (
    input  logic                     clk,
    input  logic                     btnc_i,
    input  logic                     fetch_valid,
    input  logic [DW-1:0]            fetch_instr0,
    input  logic [DW-1:0]            fetch_instr1,
    input  logic [DW-1:0]            fetch_pc,
    output logic                     fetch_ready,
    input  logic                     flush,
    input  logic                     ex_memread_i,
    input  logic [4:0]               ex_rt_i,
    output logic                     issue_valid_i,
    output logic [DW-1:0]            issue_instr_i,
    output logic [DW-1:0]            issue_pc_i,
    output logic                     issue_valid_r,
    output logic [DW-1:0]            issue_instr_r,
    output logic [DW-1:0]            issue_pc_r,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic [CW-1:0]            pair_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] RDY_MAX = (PW+1)'(QDEPTH - 2);

    logic [DW-1:0] q_instr [QDEPTH];
    logic [DW-1:0] q_pc    [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, n_ptr;
    logic [PW:0]   count, count_nxt, pops;
    state_e        state, state_nxt;

    logic [DW-1:0] h_instr, n_instr, h_pc, n_pc;
    cls_e          h_cls, n_cls;
    logic          h_br, n_is_branch_unused;
    logic [31:0]   h_src, n_src;
    logic [4:0]    h_dst, n_dst;
    logic          h_dst_vld, n_dst_vld;

    logic push, lu_h, lu_n, conflict, pop_h, pop_n;
    logic set_i, set_r;
    logic [DW-1:0] nxt_instr_i, nxt_pc_i, nxt_instr_r, nxt_pc_r;

    assign n_ptr   = rd_ptr + 1'b1;
    assign h_instr = q_instr[rd_ptr];
    assign n_instr = q_instr[n_ptr];
    assign h_pc    = q_pc[rd_ptr];
    assign n_pc    = q_pc[n_ptr];

    inst_decode_lite u_dec_h (
        .instr     (h_instr[31:11]),
        .cls       (h_cls),
        .is_branch (h_br),
        .src       (h_src),
        .dst       (h_dst),
        .dst_vld   (h_dst_vld)
    );

    inst_decode_lite u_dec_n (
        .instr     (n_instr[31:11]),
        .cls       (n_cls),
        .is_branch (n_is_branch_unused),
        .src       (n_src),
        .dst       (n_dst),
        .dst_vld   (n_dst_vld)
    );

    assign q_count     = count;
    assign fetch_ready = (count <= RDY_MAX);
    assign push        = fetch_valid && fetch_ready && !flush;

    assign lu_h = ex_memread_i && (ex_rt_i != 5'd0) && h_src[ex_rt_i];
    assign lu_n = ex_memread_i && (ex_rt_i != 5'd0) && n_src[ex_rt_i];
    assign conflict = h_dst_vld &&
                      (n_src[h_dst] || (n_dst_vld && n_dst == h_dst));

    assign pop_h = (count != '0) && !lu_h;
    assign pop_n = pop_h && (count >= (PW+1)'(2)) && (n_cls != h_cls)
                   && !h_br && !conflict && !lu_n;

    assign pops = (PW+1)'(pop_h) + (PW+1)'(pop_n);
    assign count_nxt = flush ? '0 :
                       count + (push ? (PW+1)'(2) : '0) - pops;

    // NOPs leave the queue like real instructions but never raise a valid.
    always_comb begin
        set_i       = 1'b0;
        set_r       = 1'b0;
        nxt_instr_i = h_instr;
        nxt_pc_i    = h_pc;
        nxt_instr_r = h_instr;
        nxt_pc_r    = h_pc;
        if (pop_h && h_instr != '0) begin
            if (h_cls == CLS_R) set_r = 1'b1;
            else                set_i = 1'b1;
        end
        if (pop_n && n_instr != '0) begin
            if (n_cls == CLS_R) begin
                set_r       = 1'b1;
                nxt_instr_r = n_instr;
                nxt_pc_r    = n_pc;
            end else begin
                set_i       = 1'b1;
                nxt_instr_i = n_instr;
                nxt_pc_i    = n_pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:    if (push) state_nxt = ISSUE;
            ISSUE:    if (count_nxt == '0) state_nxt = EMPTY;
                      else if (count != '0 && lu_h) state_nxt = LU_STALL;
            LU_STALL: state_nxt = (count_nxt == '0) ? EMPTY : ISSUE;
            default:  state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= fetch_instr0;
            q_instr[wr_ptr + 1'b1] <= fetch_instr1;
            q_pc[wr_ptr] <= fetch_pc;
            q_pc[wr_ptr + 1'b1] <= fetch_pc + DW'(4);
        end
    end

    always_ff @(posedge clk or negedge btnc_i) begin
        if (!btnc_i) begin
            state         <= EMPTY;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            issue_valid_i <= 1'b0;
            issue_instr_i <= '0;
            issue_pc_i    <= '0;
            issue_valid_r <= 1'b0;
            issue_instr_r <= '0;
            issue_pc_r    <= '0;
            pair_cnt      <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (flush) begin
                rd_ptr        <= wr_ptr;
                issue_valid_i <= 1'b0;
                issue_valid_r <= 1'b0;
            end else begin
                rd_ptr        <= rd_ptr + PW'(pops);
                issue_valid_i <= set_i;
                issue_valid_r <= set_r;
                if (push) wr_ptr <= wr_ptr + PW'(2);
                if (set_i) begin
                    issue_instr_i <= nxt_instr_i;
                    issue_pc_i    <= nxt_pc_i;
                end
                if (set_r) begin
                    issue_instr_r <= nxt_instr_r;
                    issue_pc_r    <= nxt_pc_r;
                end
                if (set_i && set_r && pair_cnt != '1)
                    pair_cnt <= pair_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios plus random traffic
// compared against a queue-level reference model.
module tb_dual_issue_scheduler;

    localparam int QDEPTH = 4;
    localparam int DW     = 32;
    localparam int CW     = 16;

    logic          clk = 1'b0;
    logic          btnc_i = 1'b0;
    logic          fetch_valid = 1'b0;
    logic [DW-1:0] fetch_instr0 = '0;
    logic [DW-1:0] fetch_instr1 = '0;
    logic [DW-1:0] fetch_pc = '0;
    logic          fetch_ready;
    logic          flush = 1'b0;
    logic          ex_memread_i = 1'b0;
    logic [4:0]    ex_rt_i = '0;
    logic          issue_valid_i, issue_valid_r;
    logic [DW-1:0] issue_instr_i, issue_pc_i, issue_instr_r, issue_pc_r;
    logic [2:0]    q_count;
    logic [CW-1:0] pair_cnt;

    always #5 clk = ~clk;

    dual_issue_scheduler #(.QDEPTH(QDEPTH), .DW(DW), .CW(CW)) dut (
        .clk           (clk),
        .btnc_i        (btnc_i),
        .fetch_valid   (fetch_valid),
        .fetch_instr0  (fetch_instr0),
        .fetch_instr1  (fetch_instr1),
        .fetch_pc      (fetch_pc),
        .fetch_ready   (fetch_ready),
        .flush         (flush),
        .ex_memread_i  (ex_memread_i),
        .ex_rt_i       (ex_rt_i),
        .issue_valid_i (issue_valid_i),
        .issue_instr_i (issue_instr_i),
        .issue_pc_i    (issue_pc_i),
        .issue_valid_r (issue_valid_r),
        .issue_instr_r (issue_instr_r),
        .issue_pc_r    (issue_pc_r),
        .q_count       (q_count),
        .pair_cnt      (pair_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic        e_vi, e_vr;
    logic [31:0] e_ii, e_pi, e_ir, e_pr;
    logic [15:0] e_pair;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic bit is_r(input logic [31:0] x);
        return x[31:26] == 6'h00;
    endfunction

    function automatic bit is_br(input logic [31:0] x);
        return x[31:26] == 6'h04 || x[31:26] == 6'h05;
    endfunction

    function automatic int dst_of(input logic [31:0] x);
        if (x[31:26] == 6'h00) return int'(x[15:11]);
        if (x[31:26] == 6'h23 || x[31:26] == 6'h08) return int'(x[20:16]);
        return 0;
    endfunction

    function automatic bit reads(input logic [31:0] x, input int r);
        logic [5:0] op;
        op = x[31:26];
        if (r == 0) return 1'b0;
        if (int'(x[25:21]) == r) return 1'b1;
        if ((op == 6'h00 || op == 6'h2B || is_br(x)) && int'(x[20:16]) == r)
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        e_vi = 0; e_vr = 0;
        e_ii = 0; e_pi = 0; e_ir = 0; e_pr = 0;
        e_pair = 0;
    endtask

    task automatic model_step(input bit fv, input logic [31:0] i0,
                              input logic [31:0] i1, input logic [31:0] pc,
                              input bit fl, input bit mr, input int rt);
        bit   ready, vi, vr;
        int   npop, d;
        ent_t e;
        ready = mq.size() <= QDEPTH - 2;
        vi = 0; vr = 0; npop = 0;
        if (fl) begin
            mq.delete();
            e_vi = 0; e_vr = 0;
            return;
        end
        if (mq.size() > 0 && !(mr && reads(mq[0].instr, rt))) begin
            npop = 1;
            if (mq.size() > 1) begin
                d = dst_of(mq[0].instr);
                if (is_r(mq[0].instr) != is_r(mq[1].instr)
                    && !is_br(mq[0].instr)
                    && !(d != 0 && (reads(mq[1].instr, d)
                                    || dst_of(mq[1].instr) == d))
                    && !(mr && reads(mq[1].instr, rt)))
                    npop = 2;
            end
        end
        for (int k = 0; k < npop; k++) begin
            e = mq.pop_front();
            if (e.instr != 0) begin
                if (is_r(e.instr)) begin
                    vr = 1; e_ir = e.instr; e_pr = e.pc;
                end else begin
                    vi = 1; e_ii = e.instr; e_pi = e.pc;
                end
            end
        end
        if (fv && ready) begin
            mq.push_back('{i0, pc});
            mq.push_back('{i1, pc + 32'd4});
        end
        e_vi = vi; e_vr = vr;
        if (vi && vr && e_pair != 16'hFFFF) e_pair++;
    endtask

    task automatic check_all();
        chk("valid_i", issue_valid_i, e_vi);
        chk("valid_r", issue_valid_r, e_vr);
        chk("instr_i", issue_instr_i, e_ii);
        chk("pc_i", issue_pc_i, e_pi);
        chk("instr_r", issue_instr_r, e_ir);
        chk("pc_r", issue_pc_r, e_pr);
        chk("q_count", q_count, mq.size());
        chk("fetch_ready", fetch_ready, mq.size() <= QDEPTH - 2);
        chk("pair_cnt", pair_cnt, e_pair);
    endtask

    task automatic step(input bit fv, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [31:0] pc,
                        input bit fl, input bit mr, input int rt);
        fetch_valid  = fv;
        fetch_instr0 = i0;
        fetch_instr1 = i1;
        fetch_pc     = pc;
        flush        = fl;
        ex_memread_i = mr;
        ex_rt_i      = 5'(rt);
        model_step(fv, i0, i1, pc, fl, mr, rt);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit mr, input int rt);
        step(0, 32'h0, 32'h0, 32'h0, 0, mr, rt);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1, 2:    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            3:       return {6'h23, rs, rt, imm};
            4:       return {6'h2B, rs, rt, imm};
            5:       return {6'h04, rs, rt, imm};
            6:       return {6'h05, rs, rt, imm};
            default: return {6'h08, rs, rt, imm};
        endcase
    endfunction

    logic [15:0] pc_snap;
    logic [31:0] r0, r1;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        btnc_i = 1'b1;

        // intra-pair co-issue
        step(1, 32'h00221820, 32'h8CA40000, 32'h100, 0, 0, 0);
        idle(0, 0);
        chk("pair_r", issue_instr_r, 32'h00221820);
        chk("pair_i", issue_instr_i, 32'h8CA40000);
        chk("pair_v", {issue_valid_i, issue_valid_r}, 2'b11);
        chk("pair_cnt1", pair_cnt, 1);
        idle(0, 0);

        // asynchronous reset with three entries queued
        step(1, 32'h00221820, 32'h00843020, 32'h900, 0, 0, 0);
        step(1, 32'h00A53820, 32'h20080001, 32'h908, 0, 0, 0);
        chk("rst_pre_cnt", q_count, 3);
        fetch_valid = 0;
        #2 btnc_i = 1'b0;
        #1;
        chk("rst_vi", issue_valid_i, 0);
        chk("rst_vr", issue_valid_r, 0);
        chk("rst_cnt", q_count, 0);
        chk("rst_rdy", fetch_ready, 1);
        chk("rst_pair", pair_cnt, 0);
        model_reset();
        @(negedge clk);
        btnc_i = 1'b1;
        check_all();

        // RAW inside a pair splits issue
        pc_snap = e_pair;
        step(1, 32'h20010005, 32'h00211020, 32'h200, 0, 0, 0);
        idle(0, 0);
        chk("raw_addi", {issue_valid_i, issue_valid_r, issue_instr_i},
            {2'b10, 32'h20010005});
        idle(0, 0);
        chk("raw_add", {issue_valid_i, issue_valid_r, issue_instr_r},
            {2'b01, 32'h00211020});
        chk("raw_pair", pair_cnt, pc_snap);
        idle(0, 0);

        // load-use bubble
        step(1, 32'h00843020, 32'h0, 32'h300, 0, 0, 0);
        idle(1, 4);
        chk("lu_bubble", {issue_valid_i, issue_valid_r}, 2'b00);
        chk("lu_cnt", q_count, 2);
        idle(0, 0);
        chk("lu_add", {issue_valid_r, issue_instr_r}, {1'b1, 32'h00843020});
        idle(0, 0);

        // fill under a held load-use hit, third offer ignored
        step(1, 32'h00843020, 32'h0, 32'h400, 0, 1, 4);
        step(1, 32'h00A53820, 32'h20080001, 32'h500, 0, 1, 4);
        chk("full_cnt", q_count, 4);
        chk("full_rdy", fetch_ready, 0);
        step(1, 32'h01294820, 32'h01294820, 32'h600, 0, 1, 4);
        chk("full_ign", q_count, 4);
        idle(0, 0);
        chk("full_head", {issue_valid_r, issue_pc_r}, {1'b1, 32'h400});
        repeat (3) idle(0, 0);

        // flush beats a same-cycle push
        step(1, 32'h00843020, 32'h0, 32'h700, 0, 1, 4);
        step(1, 32'h00A53820, 32'h20080001, 32'h708, 0, 1, 4);
        chk("fl_pre", q_count, 4);
        step(1, 32'h01294820, 32'h8D2A0000, 32'h800, 1, 1, 4);
        chk("fl_cnt", q_count, 0);
        chk("fl_v", {issue_valid_i, issue_valid_r}, 2'b00);
        idle(0, 0);
        chk("fl_absent", {issue_valid_i, issue_valid_r, q_count}, 5'd0);

        // wrapped ring, three pairs in order
        step(1, 32'h00221820, 32'h8CA40000, 32'hA00, 0, 0, 0);
        step(1, 32'h20010005, 32'h00211020, 32'hA08, 0, 0, 0);
        step(1, 32'h00A53820, 32'h20080001, 32'hA10, 0, 0, 0);
        repeat (6) idle(0, 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            r0 = rand_instr();
            r1 = rand_instr();
            step($urandom_range(0, 9) < 6, r0, r1,
                 32'($urandom_range(0, 4095)) << 2,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
